// File: rtl/pool_feature_streamer.sv
// Ping-pong frame buffer: pooled beats (all channels per position) in, channel-major features out.
// First feature two cycles after the last input beat; feat_* hold while feat_ready=0, in_ready drops when both banks are full.
module pool_feature_streamer #(
    parameter int DW    = 8,
    parameter int N_CH  = 4,
    parameter int N_POS = 169
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic                 in_ready,
    input  logic                 feat_ready,
    output logic                 feat_valid,
    output logic [DW-1:0]        feat_data,
    output logic                 feat_first,
    output logic                 feat_last,
    output logic                 drop_err
);
    localparam int WW = N_CH * DW;
    localparam int PW = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW = $clog2(2 * N_POS);
    localparam logic [PW-1:0] POS_MAX    = PW'(N_POS - 1);
    localparam logic [CW-1:0] CH_MAX     = CW'(N_CH - 1);
    localparam logic [AW-1:0] BANK1_BASE = AW'(N_POS);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
    state_t state, state_nxt;

    logic [WW-1:0] mem [0:2*N_POS-1];
    logic [WW-1:0] rd_word;
    logic [1:0]    full, full_nxt;
    logic          wr_bank, rd_bank;
    logic [PW-1:0] wr_pos, rd_pos, pos_nxt;
    logic [CW-1:0] rd_ch;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_en, wr_done, xfer, at_last, rd_done, rd_en;

    assign in_ready = !full[wr_bank];
    assign wr_en    = in_valid && in_ready;
    assign wr_done  = wr_en && (wr_pos == POS_MAX);
    assign at_last  = (rd_ch == CH_MAX) && (rd_pos == POS_MAX);
    assign xfer     = (state == STREAM) && feat_ready;
    assign rd_done  = xfer && at_last;
    assign pos_nxt  = (rd_pos == POS_MAX) ? '0 : rd_pos + PW'(1);
    // LOAD fetches word 0; every non-final transfer prefetches the word for the following beat
    assign rd_en    = (state == LOAD) || (xfer && !at_last);
    assign wr_addr  = (wr_bank ? BANK1_BASE : '0) + AW'(wr_pos);
    assign rd_addr  = (rd_bank ? BANK1_BASE : '0) + AW'((state == LOAD) ? rd_pos : pos_nxt);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= in_data;
        if (rd_en)
            rd_word <= mem[rd_addr];
    end

    // Banks written and read are always different, so set and clear never collide
    always_comb begin
        full_nxt = full;
        if (rd_done)
            full_nxt[rd_bank] = 1'b0;
        if (wr_done)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_pos   <= '0;
            full     <= '0;
            drop_err <= 1'b0;
        end else begin
            if (wr_en)
                wr_pos <= wr_done ? '0 : wr_pos + PW'(1);
            if (wr_done)
                wr_bank <= !wr_bank;
            if (rd_done)
                rd_bank <= !rd_bank;
            full <= full_nxt;
            if (in_valid && !in_ready)
                drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pos <= '0;
            rd_ch  <= '0;
        end else if (state == IDLE || rd_done) begin
            rd_pos <= '0;
            rd_ch  <= '0;
        end else if (xfer) begin
            rd_pos <= pos_nxt;
            if (rd_pos == POS_MAX)
                rd_ch <= rd_ch + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (full[rd_bank]) state_nxt = LOAD;
            LOAD:    state_nxt = STREAM;
            STREAM:  if (rd_done) state_nxt = full[~rd_bank] ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        feat_valid = 1'b0;
        feat_first = 1'b0;
        feat_last  = 1'b0;
        feat_data  = '0;
        if (state == STREAM) begin
            feat_valid = 1'b1;
            feat_first = (rd_ch == '0) && (rd_pos == '0);
            feat_last  = at_last;
            for (int c = 0; c < N_CH; c++)
                if (rd_ch == CW'(c))
                    feat_data = rd_word[c*DW +: DW];
        end
    end
endmodule

// File: tb/tb_pool_feature_streamer.sv
// Bench for pool_feature_streamer: scoreboard of channel-major features plus directed corner sequences.
module tb_pool_feature_streamer;
    localparam int DW = 8, N_CH = 4, N_POS = 169;
    localparam int W  = N_CH * DW;
    localparam int NF = N_CH * N_POS;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, feat_ready, feat_valid, feat_first, feat_last, drop_err;
    logic [W-1:0]  in_data;
    logic [DW-1:0] feat_data;

    always #5 clk = ~clk;

    pool_feature_streamer #(.DW(DW), .N_CH(N_CH), .N_POS(N_POS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .feat_ready(feat_ready), .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_first(feat_first), .feat_last(feat_last), .drop_err(drop_err)
    );

    typedef struct packed { logic [DW-1:0] d; logic first; logic last; } item_t;
    typedef struct { int ch; int pos; logic [DW-1:0] din; int idx; int val; } vec_t;

    item_t        sb[$];
    int           first_cyc[$], last_cyc[$];
    int           cap[NF];
    logic [W-1:0] frame_buf[N_POS];
    int           errors = 0, checks = 0, cyc = 0, rdy_mode = 1, beat_idx = 0;
    bit           stall_prev = 0;
    logic [DW+2:0] stall_snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fill_frame(input int pat);
        for (int p = 0; p < N_POS; p++)
            for (int c = 0; c < N_CH; c++)
                frame_buf[p][c*DW +: DW] = DW'(p + 16*c + 53*pat);
    endtask

    // Reference order: index c*N_POS + p carries channel c of position p
    task automatic push_expected();
        item_t it;
        for (int c = 0; c < N_CH; c++)
            for (int p = 0; p < N_POS; p++) begin
                it.d     = frame_buf[p][c*DW +: DW];
                it.first = (c == 0) && (p == 0);
                it.last  = (c == N_CH-1) && (p == N_POS-1);
                sb.push_back(it);
            end
    endtask

    // Called just after a rising edge; returns just after the edge that took the last beat
    task automatic send_frame(input int pat, input bit wait_rdy, input bit keep, output int acc0_cyc);
        bit ok;
        int guard;
        if (pat >= 0) fill_frame(pat);
        if (keep) push_expected();
        acc0_cyc = -1;
        for (int p = 0; p < N_POS; p++) begin
            in_valid = 1'b1;
            in_data  = frame_buf[p];
            guard    = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (wait_rdy && !ok && guard < 3000);
            if (wait_rdy && !ok) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: beat %0d not accepted after %0d cycles", p, guard);
                break;
            end
            if (p == 0) acc0_cyc = cyc;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || feat_valid) && n < budget);
        checks++;
        if (sb.size() != 0 || feat_valid) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, feat_valid=%b", sb.size(), feat_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input string name, input int ncyc);
        bit seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            seen |= feat_valid;
        end
        chk(name, seen, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        item_t exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if ({feat_valid, feat_data, feat_first, feat_last} !== stall_snap) begin
                        errors++;
                        $display("FAIL stall_hold: got v/d/f/l=%h expected %h", {feat_valid, feat_data, feat_first, feat_last}, stall_snap);
                    end
                end
                stall_prev = feat_valid && !feat_ready;
                stall_snap = {feat_valid, feat_data, feat_first, feat_last};
                if (feat_valid && feat_ready) begin
                    if (feat_first) begin
                        beat_idx = 0;
                        first_cyc.push_back(cyc);
                    end
                    if (feat_last) last_cyc.push_back(cyc);
                    if (beat_idx < NF) cap[beat_idx] = int'($signed(feat_data));
                    beat_idx++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got data=%02h first=%b last=%b with nothing expected", feat_data, feat_first, feat_last);
                    end else begin
                        exp = sb.pop_front();
                        if (feat_data !== exp.d || feat_first !== exp.first || feat_last !== exp.last) begin
                            errors++;
                            $display("FAIL beat %0d: got data=%02h first=%b last=%b, expected data=%02h first=%b last=%b",
                                     beat_idx-1, feat_data, feat_first, feat_last, exp.d, exp.first, exp.last);
                        end
                    end
                end
            end
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       feat_ready = 1'b0;
                1:       feat_ready = 1'b1;
                default: feat_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic watchdog();
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d beats outstanding", sb.size());
        $fatal(1, "watchdog expired");
    endtask

    initial begin
        vec_t vt[4];
        int acc0, acc_dummy;
        vt[0] = '{0,   0, 8'h80,   0, -128};
        vt[1] = '{3, 168, 8'h7F, 675,  127};
        vt[2] = '{1,   5, 8'hFF, 174,   -1};
        vt[3] = '{2, 100, 8'h01, 438,    1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; feat_ready = 1'b0;
        fork
            monitor();
            rdy_driver();
            watchdog();
        join_none
        #3;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_feat_valid", feat_valid, 0);
        chk("reset_feat_data", feat_data, 0);
        chk("reset_feat_first", feat_first, 0);
        chk("reset_feat_last", feat_last, 0);
        chk("reset_drop_err", drop_err, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame, p+16c, with first-beat latency
        rdy_mode = 1;
        send_frame(0, 1'b1, 1'b1, acc_dummy);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_T_valid", feat_valid, 0);
        @(negedge clk); chk("lat_load_valid", feat_valid, 0);
        @(negedge clk); chk("lat_T2_valid", feat_valid, 1);
        chk("lat_T2_first", feat_first, 1);
        @(posedge clk); #1;
        wait_drain(2000);
        chk("single_beats", beat_idx, NF);
        chk("single_idx169", cap[169], 16);
        chk("single_idx675", cap[675], -40);

        // Sign vectors applied through the table
        fill_frame(1);
        for (int i = 0; i < 4; i++) frame_buf[vt[i].pos][vt[i].ch*DW +: DW] = vt[i].din;
        send_frame(-1, 1'b1, 1'b1, acc_dummy);
        in_valid = 1'b0;
        wait_drain(2000);
        for (int i = 0; i < 4; i++)
            chk($sformatf("sign_vec%0d_idx%0d", i, vt[i].idx), cap[vt[i].idx], vt[i].val);

        // Random backpressure
        rdy_mode = 2;
        send_frame(0, 1'b1, 1'b1, acc_dummy);
        in_valid = 1'b0;
        wait_drain(6000);
        chk("bp_beats", beat_idx, NF);
        rdy_mode = 1;

        // Overflow with the consumer stalled
        chk("pre_ovf_drop_err", drop_err, 0);
        rdy_mode = 0;
        @(posedge clk); #1;
        send_frame(2, 1'b0, 1'b1, acc_dummy);
        send_frame(3, 1'b0, 1'b1, acc_dummy);
        chk("ovf_in_ready_full", in_ready, 0);
        send_frame(4, 1'b0, 1'b0, acc_dummy);
        in_valid = 1'b0;
        chk("ovf_drop_err", drop_err, 1);
        @(negedge clk);
        chk("ovf_stall_valid", feat_valid, 1);
        chk("ovf_stall_first", feat_first, 1);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 1;
        wait_drain(4000);
        chk("ovf_drop_err_sticky", drop_err, 1);
        quiet_check("ovf_no_third_frame", 20);

        // Three frames back-to-back with continuous in_valid
        first_cyc.delete();
        last_cyc.delete();
        send_frame(5, 1'b1, 1'b1, acc_dummy);
        send_frame(6, 1'b1, 1'b1, acc_dummy);
        chk("b2b_in_ready_low", in_ready, 0);
        send_frame(7, 1'b1, 1'b1, acc0);
        in_valid = 1'b0;
        wait_drain(4000);
        chk("b2b_frames_seen", first_cyc.size(), 3);
        if (first_cyc.size() == 3 && last_cyc.size() == 3) begin
            chk("b2b_ready_rise", acc0, last_cyc[0] + 2);
            for (int k = 0; k < 2; k++)
                chk($sformatf("b2b_gap%0d", k), first_cyc[k+1] - last_cyc[k], 2);
        end

        // Reset in the middle of a stream
        send_frame(9, 1'b1, 1'b1, acc_dummy);
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_feat_valid", feat_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_drop_err", drop_err, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        quiet_check("midrst_no_stale", 10);
        send_frame(10, 1'b1, 1'b1, acc_dummy);
        in_valid = 1'b0;
        wait_drain(2000);
        chk("midrst_next_beats", beat_idx, NF);
        chk("midrst_next_idx0", cap[0], 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
